// File: rtl/sid_regfile.sv
// SID-style register file: per-voice and filter registers, read-only live ports, decaying bus latch.
// Latency: writes land on the accepting edge, read data registered one cycle later. No backpressure: one accept per chip select.
module sid_regfile #(
    parameter int          NUM_VOICES  = 3,
    parameter logic [15:0] DECAY_TICKS = 16'd2000,
    localparam int         AW          = $clog2(7*NUM_VOICES+8)
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      clk_en,
    input  logic [AW-1:0]             addr,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      n_cs,
    input  logic                      rw,
    input  logic [7:0]                osc_in,
    input  logic [7:0]                env_in,
    input  logic [7:0]                pot_x,
    input  logic [7:0]                pot_y,
    output logic [16*NUM_VOICES-1:0]  freq,
    output logic [12*NUM_VOICES-1:0]  pw,
    output logic [8*NUM_VOICES-1:0]   ctrl,
    output logic [8*NUM_VOICES-1:0]   ad,
    output logic [8*NUM_VOICES-1:0]   sr,
    output logic [NUM_VOICES-1:0]     ctrl_wr,
    output logic [10:0]               fc,
    output logic [7:0]                res_filt,
    output logic [7:0]                mode_vol
);

    localparam int F = 7*NUM_VOICES;

    logic        acc_done;
    logic        accept;
    logic        wr_acc;
    logic        rd_acc;
    logic        ro_hit;
    logic [7:0]  ro_val;
    logic        reload;
    logic [15:0] decay_cnt;
    logic [7:0]  bus_latch;

    assign accept = !n_cs && !acc_done;
    assign wr_acc = accept && !rw;
    assign rd_acc = accept && rw;

    always_comb begin
        ro_hit = 1'b0;
        ro_val = 8'h00;
        if (addr == AW'(F+4)) begin
            ro_hit = 1'b1;
            ro_val = pot_x;
        end else if (addr == AW'(F+5)) begin
            ro_hit = 1'b1;
            ro_val = pot_y;
        end else if (addr == AW'(F+6)) begin
            ro_hit = 1'b1;
            ro_val = osc_in;
        end else if (addr == AW'(F+7)) begin
            ro_hit = 1'b1;
            ro_val = env_in;
        end
    end

    // Reads that merely echo the latch must not refresh it.
    assign reload = wr_acc || (rd_acc && ro_hit);

    // acc_done tracks chip select so a long assertion yields exactly one accept.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_done <= 1'b0;
        end else begin
            acc_done <= !n_cs;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            decay_cnt <= 16'h0000;
            bus_latch <= 8'h00;
            data_out  <= 8'h00;
        end else begin
            if (reload) begin
                decay_cnt <= DECAY_TICKS;
            end else if (clk_en && decay_cnt != 16'h0000) begin
                decay_cnt <= decay_cnt - 16'h0001;
            end

            if (wr_acc) begin
                bus_latch <= data_in;
            end else if (rd_acc && ro_hit) begin
                bus_latch <= ro_val;
            end else if (clk_en && decay_cnt == 16'h0001) begin
                bus_latch <= 8'h00;
            end

            if (rd_acc) begin
                data_out <= ro_hit ? ro_val : bus_latch;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            freq     <= '0;
            pw       <= '0;
            ctrl     <= '0;
            ad       <= '0;
            sr       <= '0;
            ctrl_wr  <= '0;
            fc       <= '0;
            res_filt <= 8'h00;
            mode_vol <= 8'h00;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                ctrl_wr[v] <= wr_acc && (addr == AW'(7*v+4));
                if (wr_acc) begin
                    if (addr == AW'(7*v+0)) freq[16*v +: 8]  <= data_in;
                    if (addr == AW'(7*v+1)) freq[16*v+8 +: 8] <= data_in;
                    if (addr == AW'(7*v+2)) pw[12*v +: 8]    <= data_in;
                    if (addr == AW'(7*v+3)) pw[12*v+8 +: 4]  <= data_in[3:0];
                    if (addr == AW'(7*v+4)) ctrl[8*v +: 8]   <= data_in;
                    if (addr == AW'(7*v+5)) ad[8*v +: 8]     <= data_in;
                    if (addr == AW'(7*v+6)) sr[8*v +: 8]     <= data_in;
                end
            end
            if (wr_acc) begin
                if (addr == AW'(F+0)) fc[2:0]  <= data_in[2:0];
                if (addr == AW'(F+1)) fc[10:3] <= data_in;
                if (addr == AW'(F+2)) res_filt <= data_in;
                if (addr == AW'(F+3)) mode_vol <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_sid_regfile.sv
// Bench for sid_regfile: default 3-voice instance with short decay, plus a 5-voice instance.
module tb_sid_regfile;

    logic        clk;
    logic        n_reset;
    logic        clk_en;
    logic        rw;
    logic [7:0]  data_in;
    logic [7:0]  osc_in, env_in, pot_x, pot_y;

    logic [4:0]  addr;
    logic        n_cs;
    logic [7:0]  data_out;
    logic [47:0] freq;
    logic [35:0] pw;
    logic [23:0] ctrl, ad, sr;
    logic [2:0]  ctrl_wr;
    logic [10:0] fc;
    logic [7:0]  res_filt, mode_vol;

    logic [5:0]  addr5;
    logic        n_cs5;
    logic [7:0]  data_out5;
    logic [79:0] freq5;
    logic [59:0] pw5;
    logic [39:0] ctrl5, ad5, sr5;
    logic [4:0]  ctrl_wr5;
    logic [10:0] fc5;
    logic [7:0]  res_filt5, mode_vol5;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    sid_regfile #(.NUM_VOICES(3), .DECAY_TICKS(16'd4)) u_dut (
        .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .addr(addr), .data_in(data_in),
        .data_out(data_out), .n_cs(n_cs), .rw(rw), .osc_in(osc_in), .env_in(env_in),
        .pot_x(pot_x), .pot_y(pot_y), .freq(freq), .pw(pw), .ctrl(ctrl), .ad(ad), .sr(sr),
        .ctrl_wr(ctrl_wr), .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol)
    );

    sid_regfile #(.NUM_VOICES(5)) u_dut5 (
        .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .addr(addr5), .data_in(data_in),
        .data_out(data_out5), .n_cs(n_cs5), .rw(rw), .osc_in(osc_in), .env_in(env_in),
        .pot_x(pot_x), .pot_y(pot_y), .freq(freq5), .pw(pw5), .ctrl(ctrl5), .ad(ad5), .sr(sr5),
        .ctrl_wr(ctrl_wr5), .fc(fc5), .res_filt(res_filt5), .mode_vol(mode_vol5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit d5, input logic [5:0] a, input logic [7:0] d, input bit en);
        rw      = 1'b0;
        data_in = d;
        clk_en  = en;
        if (d5) begin
            addr5 = a;
            n_cs5 = 1'b0;
        end else begin
            addr = a[4:0];
            n_cs = 1'b0;
        end
        cyc();
        n_cs   = 1'b1;
        n_cs5  = 1'b1;
        clk_en = 1'b0;
        cyc();
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e, input string nm);
        logic [7:0] ev;
        rw   = 1'b1;
        addr = a;
        n_cs = 1'b0;
        exp_q.push_back(e);
        cyc();
        if (exp_q.size() == 0) begin
            check({nm, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            ev = exp_q.pop_front();
            check(nm, {56'd0, data_out}, {56'd0, ev});
        end
        n_cs = 1'b1;
        rw   = 1'b0;
        cyc();
    endtask

    task automatic tick();
        clk_en = 1'b1;
        cyc();
        clk_en = 1'b0;
    endtask

    // Current 8-bit view of the register that a write to address a targets.
    function automatic logic [7:0] get_field(input logic [4:0] a);
        int v;
        int r;
        v = int'(a) / 7;
        r = int'(a) % 7;
        if (a < 5'd21) begin
            case (r)
                0: return freq[16*v +: 8];
                1: return freq[16*v+8 +: 8];
                2: return pw[12*v +: 8];
                3: return {4'h0, pw[12*v+8 +: 4]};
                4: return ctrl[8*v +: 8];
                5: return ad[8*v +: 8];
                default: return sr[8*v +: 8];
            endcase
        end
        case (a)
            5'd21:   return {5'b0, fc[2:0]};
            5'd22:   return fc[10:3];
            5'd23:   return res_filt;
            5'd24:   return mode_vol;
            default: return 8'h00;
        endcase
    endfunction

    typedef struct {
        bit         rd;
        bit         chk;
        logic [4:0] a;
        logic [7:0] din;
        logic [7:0] px;
        logic [7:0] py;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[19];

    initial begin
        int hits;
        logic [7:0] held;

        vt[0]  = '{1'b0, 1'b1, 5'h00, 8'h34, 8'h00, 8'h00, 8'h34};
        vt[1]  = '{1'b0, 1'b1, 5'h01, 8'h12, 8'h00, 8'h00, 8'h12};
        vt[2]  = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00, 8'h12};
        vt[3]  = '{1'b0, 1'b1, 5'h03, 8'hFF, 8'h00, 8'h00, 8'h0F};
        vt[4]  = '{1'b1, 1'b0, 5'h05, 8'h00, 8'h00, 8'h00, 8'hFF};
        vt[5]  = '{1'b0, 1'b1, 5'h09, 8'h5A, 8'h00, 8'h00, 8'h5A};
        vt[6]  = '{1'b0, 1'b1, 5'h0E, 8'hC3, 8'h00, 8'h00, 8'hC3};
        vt[7]  = '{1'b0, 1'b1, 5'h15, 8'hFF, 8'h00, 8'h00, 8'h07};
        vt[8]  = '{1'b0, 1'b1, 5'h16, 8'hAB, 8'h00, 8'h00, 8'hAB};
        vt[9]  = '{1'b0, 1'b1, 5'h17, 8'hF3, 8'h00, 8'h00, 8'hF3};
        vt[10] = '{1'b0, 1'b1, 5'h18, 8'h8F, 8'h00, 8'h00, 8'h8F};
        vt[11] = '{1'b0, 1'b1, 5'h13, 8'hA7, 8'h00, 8'h00, 8'hA7};
        vt[12] = '{1'b0, 1'b0, 5'h19, 8'h77, 8'h00, 8'h00, 8'h00};
        vt[13] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00, 8'h77};
        vt[14] = '{1'b1, 1'b0, 5'h19, 8'h00, 8'h11, 8'h00, 8'h11};
        vt[15] = '{1'b1, 1'b0, 5'h1A, 8'h00, 8'h11, 8'h22, 8'h22};
        vt[16] = '{1'b1, 1'b0, 5'h04, 8'h00, 8'h11, 8'h22, 8'h22};
        vt[17] = '{1'b0, 1'b0, 5'h1E, 8'h66, 8'h11, 8'h22, 8'h00};
        vt[18] = '{1'b1, 1'b0, 5'h1F, 8'h00, 8'h11, 8'h22, 8'h66};

        n_reset = 1'b0;
        clk_en  = 1'b0;
        rw      = 1'b0;
        data_in = 8'h00;
        addr    = '0;
        addr5   = '0;
        n_cs    = 1'b1;
        n_cs5   = 1'b1;
        osc_in  = 8'h00;
        env_in  = 8'h00;
        pot_x   = 8'h00;
        pot_y   = 8'h00;
        cyc();
        cyc();
        check("rst data_out", {56'd0, data_out}, 64'd0);
        check("rst freq", {16'd0, freq}, 64'd0);
        check("rst ctrl_wr", {61'd0, ctrl_wr}, 64'd0);
        check("rst fc", {53'd0, fc}, 64'd0);
        n_reset = 1'b1;
        cyc();

        for (int i = 0; i < 19; i++) begin
            pot_x = vt[i].px;
            pot_y = vt[i].py;
            if (vt[i].rd) begin
                rd(vt[i].a, vt[i].exp, $sformatf("vec%0d read", i));
            end else begin
                wr(1'b0, {1'b0, vt[i].a}, vt[i].din, 1'b0);
                if (vt[i].chk)
                    check($sformatf("vec%0d field", i), {56'd0, get_field(vt[i].a)}, {56'd0, vt[i].exp});
            end
        end
        check("freq all voices", {16'd0, freq}, {16'd0, 16'h00C3, 16'h0000, 16'h1234});
        check("pw all voices", {28'd0, pw}, {28'd0, 12'h000, 12'h05A, 12'hF00});
        check("fc full", {53'd0, fc}, {53'd0, 11'h55F});
        check("ad all voices", {40'd0, ad}, {40'd0, 8'hA7, 8'h00, 8'h00});

        // data_out must hold while no read is accepted
        held = data_out;
        addr = 5'h19;
        pot_x = 8'hEE;
        repeat (3) cyc();
        check("data_out hold", {56'd0, data_out}, {56'd0, held});

        // ctrl write with chip select held for five cycles
        hits    = 0;
        rw      = 1'b0;
        addr    = 5'h04;
        data_in = 8'h41;
        n_cs    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 0) check("ctrl_wr first cycle", {61'd0, ctrl_wr}, 64'd1);
            hits += int'(ctrl_wr[0]);
            data_in = 8'h99;
        end
        n_cs = 1'b1;
        cyc();
        check("ctrl_wr pulse count", hits, 64'd1);
        check("ctrl value single accept", {56'd0, ctrl[7:0]}, 64'h41);
        check("ctrl_wr idle", {61'd0, ctrl_wr}, 64'd0);
        rd(5'h00, 8'h41, "latch single accept");

        // latch decay boundary
        wr(1'b0, 6'h00, 8'hA5, 1'b0);
        rd(5'h00, 8'hA5, "latch after write");
        repeat (3) tick();
        rd(5'h00, 8'hA5, "latch before expiry");
        tick();
        rd(5'h00, 8'h00, "latch decayed");
        tick();
        rd(5'h00, 8'h00, "latch stays zero");

        // live read-only ports
        env_in = 8'h7F;
        rd(5'h1C, 8'h7F, "env_in read");
        osc_in = 8'h3C;
        rd(5'h1B, 8'h3C, "osc_in read");

        // access coincident with clk_en: full reload, no decrement
        wr(1'b0, 6'h05, 8'h5C, 1'b1);
        repeat (3) tick();
        rd(5'h00, 8'h5C, "reload wins");
        tick();
        rd(5'h00, 8'h00, "reload then decay");

        // async reset mid-write, chip select held across release
        rw      = 1'b0;
        addr    = 5'h04;
        data_in = 8'h77;
        n_cs    = 1'b0;
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        check("arst freq", {16'd0, freq}, 64'd0);
        check("arst pw", {28'd0, pw}, 64'd0);
        check("arst ctrl", {40'd0, ctrl}, 64'd0);
        check("arst ad", {40'd0, ad}, 64'd0);
        check("arst sr", {40'd0, sr}, 64'd0);
        check("arst ctrl_wr", {61'd0, ctrl_wr}, 64'd0);
        check("arst fc/rf/mv", {37'd0, fc, res_filt, mode_vol}, 64'd0);
        check("arst data_out", {56'd0, data_out}, 64'd0);
        #2;
        n_reset = 1'b1;
        cyc();
        check("accept after release", {56'd0, ctrl[7:0]}, 64'h77);
        check("ctrl_wr after release", {61'd0, ctrl_wr}, 64'd1);
        n_cs = 1'b1;
        cyc();
        rd(5'h00, 8'h77, "latch after release");

        // five-voice instance
        wr(1'b1, 6'h23, 8'hFF, 1'b0);
        check("n5 fc low bits", {53'd0, fc5}, 64'h007);
        wr(1'b1, 6'd31, 8'h80, 1'b0);
        check("n5 pw hi 0x80", {52'd0, pw5[59:48]}, 64'h000);
        wr(1'b1, 6'd31, 8'h8A, 1'b0);
        check("n5 pw hi nibble", {52'd0, pw5[59:48]}, 64'hA00);
        wr(1'b1, 6'd34, 8'h80, 1'b0);
        check("n5 sr voice4", {56'd0, sr5[39:32]}, 64'h80);
        check("n5 pw untouched", {52'd0, pw5[59:48]}, 64'hA00);
        check("n5 other pw", {16'd0, pw5[47:0]}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
